// File: rtl/coin_change_ctrl.sv
// coin_change_ctrl - vending credit / change controller.
// Accepts 100 and 500 coins up to MAX_CREDIT. A purchase or cancel moves the
// controller into CHANGE, where the change value is held for HOLD_CYCLES
// cycles. All outputs are registered.
// Optional feature: define TIMEOUT_EN to enable an inactivity timeout in
// COLLECT that behaves exactly like a cancel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no credit; waiting for the first accepted coin
// COLLECT | credit accumulating; buy / cancel accepted
// CHANGE  | change value presented on vuelto with vuelto_en high
module coin_change_ctrl #(
    parameter logic [11:0] PRICE0         = 12'd300,
    parameter logic [11:0] PRICE1         = 12'd500,
    parameter logic [11:0] PRICE2         = 12'd800,
    parameter logic [11:0] PRICE3         = 12'd1200,
    parameter logic [11:0] MAX_CREDIT     = 12'd1500,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        coin_100,
    input  logic        coin_500,
    input  logic [1:0]  sel,
    input  logic        buy,
    input  logic        cancel,
    output logic [11:0] credit,
    output logic [11:0] vuelto,
    output logic        vuelto_en,
    output logic        dispense,
    output logic [1:0]  product,
    output logic        coin_reject
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [11:0]   credit_q;
    logic [11:0]   vuelto_q;
    logic          vuelto_en_q;
    logic          dispense_q;
    logic [1:0]    product_q;
    logic          coin_reject_q;
    logic [HW-1:0] hold_q;

    logic [11:0]   coin_val;
    logic [12:0]   coin_sum;
    logic          coin_any;
    logic          coin_fits;
    logic [11:0]   price_sel;
    logic          buy_ok;
    logic          cancel_eff;
    logic          coin_accept;

`ifdef TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q;

    // Inactivity expiry is folded into the cancel path so both share one exit.
    assign cancel_eff = cancel || (state_q == COLLECT && idle_q == '0);
`else
    assign cancel_eff = cancel;
`endif

    // Coin value, fit check, selected price and the resulting coin decision.
    always_comb begin
        coin_val  = (coin_100 ? 12'd100 : 12'd0) + (coin_500 ? 12'd500 : 12'd0);
        coin_any  = coin_100 || coin_500;
        coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits = (coin_sum <= {1'b0, MAX_CREDIT});
        price_sel = PRICE0;
        case (sel)
            2'd0:    price_sel = PRICE0;
            2'd1:    price_sel = PRICE1;
            2'd2:    price_sel = PRICE2;
            default: price_sel = PRICE3;
        endcase
        buy_ok      = buy && (credit_q >= price_sel);
        // A coin arriving with a committed buy/cancel is bounced, never added.
        coin_accept = coin_any && coin_fits &&
                      ((state_q == IDLE) ||
                       (state_q == COLLECT && !cancel_eff && !buy_ok));
    end

    // Main controller: state, credit, change hold and registered pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            vuelto_q      <= '0;
            vuelto_en_q   <= 1'b0;
            dispense_q    <= 1'b0;
            product_q     <= '0;
            coin_reject_q <= 1'b0;
            hold_q        <= '0;
`ifdef TIMEOUT_EN
            idle_q        <= '0;
`endif
        end else begin
            dispense_q    <= 1'b0;
            coin_reject_q <= coin_any && !coin_accept;
            if (coin_accept) begin
                credit_q <= coin_sum[11:0];
            end
            case (state_q)
                IDLE: begin
                    if (coin_accept) begin
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel_eff) begin
                        vuelto_q    <= credit_q;
                        vuelto_en_q <= 1'b1;
                        credit_q    <= '0;
                        hold_q      <= HW'(HOLD_CYCLES - 1);
                        state_q     <= CHANGE;
                    end else if (buy_ok) begin
                        dispense_q  <= 1'b1;
                        product_q   <= sel;
                        vuelto_q    <= credit_q - price_sel;
                        vuelto_en_q <= 1'b1;
                        credit_q    <= '0;
                        hold_q      <= HW'(HOLD_CYCLES - 1);
                        state_q     <= CHANGE;
                    end
                end
                CHANGE: begin
                    if (hold_q == '0) begin
                        vuelto_en_q <= 1'b0;
                        vuelto_q    <= '0;
                        state_q     <= IDLE;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef TIMEOUT_EN
            if (coin_accept) begin
                idle_q <= IW'(TIMEOUT_CYCLES - 1);
            end else if (state_q == COLLECT && idle_q != '0) begin
                idle_q <= idle_q - 1'b1;
            end
`endif
        end
    end

    assign credit      = credit_q;
    assign vuelto      = vuelto_q;
    assign vuelto_en   = vuelto_en_q;
    assign dispense    = dispense_q;
    assign product     = product_q;
    assign coin_reject = coin_reject_q;

endmodule
